// File: rtl/raytrace_pkg.sv
// Shared definitions for the ray/sphere intersection pipeline.
//   - default widths (W, FRAC, TAG_W, CNT_W) and the CW = W + 4 derivation
//   - vec3 component slice helper for packed {x,y,z} vectors
//   - saturate-to-width helper for signed values
package raytrace_pkg;

    localparam int unsigned RT_W     = 16;
    localparam int unsigned RT_FRAC  = 8;
    localparam int unsigned RT_TAG_W = 8;
    localparam int unsigned RT_CNT_W = 32;
    localparam int unsigned CW_EXTRA = 4;

    // Width of the a/h/c terms after the FRAC shift.
    function automatic int unsigned cw_of(input int unsigned w);
        return w + CW_EXTRA;
    endfunction

    // LSB of component idx (0=x, 1=y, 2=z) inside a packed {x,y,z} vector.
    function automatic int unsigned vec_lsb(input int unsigned idx, input int unsigned w);
        return (2 - idx) * w;
    endfunction

    // Clamp a signed value to the range of a w-bit two's complement number.
    function automatic logic signed [63:0] sat_to(input logic signed [63:0] x,
                                                  input int unsigned       w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/dot3_fx.sv
// Registered three-term signed dot product, two cycles of latency.
//   Cycle 1: three exact products registered.
//   Cycle 2: products summed, optional bias subtracted, arithmetic shift right
//            by FRAC, saturation to OUT_W bits, result registered.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en_i              both register stages advance only when high
//   a0_i..a2_i        first operand components (AW bits, signed)
//   b0_i..b2_i        second operand components (BW bits, signed)
//   bias_i            value subtracted from the full-precision sum (cycle-2 aligned)
//   y_o               saturated, shifted result (OUT_W bits, signed)
module dot3_fx
    import raytrace_pkg::*;
#(
    parameter int unsigned AW    = RT_W + 1,
    parameter int unsigned BW    = RT_W,
    parameter int unsigned FRAC  = RT_FRAC,
    parameter int unsigned OUT_W = RT_W + CW_EXTRA
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_i,
    input  logic signed [AW-1:0]      a0_i,
    input  logic signed [AW-1:0]      a1_i,
    input  logic signed [AW-1:0]      a2_i,
    input  logic signed [BW-1:0]      b0_i,
    input  logic signed [BW-1:0]      b1_i,
    input  logic signed [BW-1:0]      b2_i,
    input  logic signed [AW+BW+1:0]   bias_i,
    output logic signed [OUT_W-1:0]   y_o
);

    localparam int unsigned PW = AW + BW;
    localparam int unsigned SW = PW + 2;

    logic signed [PW-1:0]    p0_d, p1_d, p2_d;
    logic signed [PW-1:0]    p0_q, p1_q, p2_q;
    logic signed [SW-1:0]    sum_c;
    logic signed [SW:0]      diff_c;
    logic signed [SW:0]      shr_c;
    logic signed [OUT_W-1:0] y_d, y_q;

    // Products at full precision, then sum/bias/shift/saturate.
    always_comb begin
        p0_d   = PW'(a0_i) * PW'(b0_i);
        p1_d   = PW'(a1_i) * PW'(b1_i);
        p2_d   = PW'(a2_i) * PW'(b2_i);
        sum_c  = SW'(p0_q) + SW'(p1_q) + SW'(p2_q);
        diff_c = (SW+1)'(sum_c) - (SW+1)'(bias_i);
        shr_c  = diff_c >>> FRAC;
        y_d    = OUT_W'(sat_to(64'(shr_c), OUT_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_q <= '0;
            p1_q <= '0;
            p2_q <= '0;
            y_q  <= '0;
        end else if (en_i) begin
            p0_q <= p0_d;
            p1_q <= p1_d;
            p2_q <= p2_d;
            y_q  <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/ray_sphere_pipe.sv
// Pipelined fixed-point ray/sphere intersection test (half-b discriminant form).
//   S1: oc = orig - center; dir, radius, tag registered
//   S2: nine component products (inside dot3_fx) and r*r
//   S3: sums, shift by FRAC, saturate to CW = W+4 -> a, h, c
//   S4: disc = h*h - a*c, hit = disc > 0 -> output register
// Latency 4 cycles, one transaction per cycle; the whole pipe freezes on
// output back-pressure (adv = !out_valid || out_ready).
// Optional build macro RAY_SPHERE_DISC_OUT_EN adds the out_disc port.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   ray_orig, ray_dir     {x,y,z} signed Q(W-FRAC).FRAC vectors
//   sph_center, sph_rad   sphere centre and radius (radius sign ignored)
//   in_tag / out_tag      opaque user tag, returned in order
//   out_valid / out_ready output handshake
//   out_hit               1 when the discriminant is strictly positive
//   hit_cnt               count of hits handed off downstream (wraps)
//   out_disc              S4 discriminant, 2*FRAC fraction bits (macro only)
module ray_sphere_pipe
    import raytrace_pkg::*;
#(
    parameter int unsigned W     = RT_W,
    parameter int unsigned FRAC  = RT_FRAC,
    parameter int unsigned TAG_W = RT_TAG_W,
    parameter int unsigned CNT_W = RT_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [3*W-1:0]                ray_orig,
    input  logic [3*W-1:0]                ray_dir,
    input  logic [3*W-1:0]                sph_center,
    input  logic [W-1:0]                  sph_rad,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_hit,
    output logic [TAG_W-1:0]              out_tag,
    output logic [CNT_W-1:0]              hit_cnt
`ifdef RAY_SPHERE_DISC_OUT_EN
    ,
    output logic signed [2*(W+CW_EXTRA):0] out_disc
`endif
);

    localparam int unsigned CW   = cw_of(W);
    localparam int unsigned OW   = W + 1;
    localparam int unsigned RW   = 2 * W;
    localparam int unsigned DW   = 2 * CW + 1;
    localparam int unsigned SWOO = 2 * OW + 2;

    logic                    adv_c;

    // S1
    logic                    v1_q;
    logic signed [OW-1:0]    oc_d  [3];
    logic signed [OW-1:0]    oc_q  [3];
    logic signed [W-1:0]     dir_d [3];
    logic signed [W-1:0]     dir_q [3];
    logic signed [W-1:0]     rad_q;
    logic [TAG_W-1:0]        tag1_q;

    // S2
    logic                    v2_q;
    logic [TAG_W-1:0]        tag2_q;
    logic signed [RW-1:0]    rr_d, rr_q;

    // S3 (a/h/c registers live inside the dot3_fx instances)
    logic                    v3_q;
    logic [TAG_W-1:0]        tag3_q;
    logic signed [CW-1:0]    a_r, h_r, c_r;

    // S4
    logic signed [DW-1:0]    disc_c;
    logic                    out_valid_q;
    logic                    out_hit_d, out_hit_q;
    logic [TAG_W-1:0]        out_tag_q;
    logic signed [DW-1:0]    disc_q;
    logic [CNT_W-1:0]        hit_cnt_d, hit_cnt_q;

    assign adv_c    = !out_valid_q || out_ready;
    assign in_ready = adv_c;

    // Next-state datapath for S1, S2, S4 and the hit counter.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            oc_d[k]  = OW'(signed'(ray_orig[vec_lsb(k, W) +: W]))
                     - OW'(signed'(sph_center[vec_lsb(k, W) +: W]));
            dir_d[k] = signed'(ray_dir[vec_lsb(k, W) +: W]);
        end
        rr_d      = RW'(rad_q) * RW'(rad_q);
        disc_c    = DW'(h_r) * DW'(h_r) - DW'(a_r) * DW'(c_r);
        // Strictly positive: sign clear and not zero; bubbles never report a hit.
        out_hit_d = v3_q && !disc_c[DW-1] && (disc_c != '0);
        hit_cnt_d = hit_cnt_q;
        if (out_valid_q && out_ready && out_hit_q) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            oc_q        <= '{default: '0};
            dir_q       <= '{default: '0};
            rad_q       <= '0;
            tag1_q      <= '0;
            v2_q        <= 1'b0;
            tag2_q      <= '0;
            rr_q        <= '0;
            v3_q        <= 1'b0;
            tag3_q      <= '0;
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_tag_q   <= '0;
            disc_q      <= '0;
        end else if (adv_c) begin
            v1_q        <= in_valid;
            oc_q        <= oc_d;
            dir_q       <= dir_d;
            rad_q       <= signed'(sph_rad);
            tag1_q      <= in_tag;
            v2_q        <= v1_q;
            tag2_q      <= tag1_q;
            rr_q        <= rr_d;
            v3_q        <= v2_q;
            tag3_q      <= tag2_q;
            out_valid_q <= v3_q;
            out_hit_q   <= out_hit_d;
            out_tag_q   <= tag3_q;
            disc_q      <= disc_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    // a = dir . dir
    dot3_fx #(.AW(W), .BW(W), .FRAC(FRAC), .OUT_W(CW)) u_dot_dd (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (adv_c),
        .a0_i   (dir_q[0]),
        .a1_i   (dir_q[1]),
        .a2_i   (dir_q[2]),
        .b0_i   (dir_q[0]),
        .b1_i   (dir_q[1]),
        .b2_i   (dir_q[2]),
        .bias_i ('0),
        .y_o    (a_r)
    );

    // h = oc . dir
    dot3_fx #(.AW(OW), .BW(W), .FRAC(FRAC), .OUT_W(CW)) u_dot_od (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (adv_c),
        .a0_i   (oc_q[0]),
        .a1_i   (oc_q[1]),
        .a2_i   (oc_q[2]),
        .b0_i   (dir_q[0]),
        .b1_i   (dir_q[1]),
        .b2_i   (dir_q[2]),
        .bias_i ('0),
        .y_o    (h_r)
    );

    // c = oc . oc - r*r; r*r is subtracted before the shift so c stays exact.
    dot3_fx #(.AW(OW), .BW(OW), .FRAC(FRAC), .OUT_W(CW)) u_dot_oo (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (adv_c),
        .a0_i   (oc_q[0]),
        .a1_i   (oc_q[1]),
        .a2_i   (oc_q[2]),
        .b0_i   (oc_q[0]),
        .b1_i   (oc_q[1]),
        .b2_i   (oc_q[2]),
        .bias_i (SWOO'(rr_q)),
        .y_o    (c_r)
    );

    assign out_valid = out_valid_q;
    assign out_hit   = out_hit_q;
    assign out_tag   = out_tag_q;
    assign hit_cnt   = hit_cnt_q;
`ifdef RAY_SPHERE_DISC_OUT_EN
    assign out_disc  = disc_q;
`endif

endmodule

// File: tb/tb_ray_sphere_pipe.sv
// Scoreboard bench for ray_sphere_pipe (W=16, FRAC=8, 1.0 = 256).
`timescale 1ns/1ps
module tb_ray_sphere_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] ray_orig = '0;
    logic [47:0] ray_dir = '0;
    logic [47:0] sph_center = '0;
    logic [15:0] sph_rad = '0;
    logic [7:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready;
    logic        out_hit;
    logic [7:0]  out_tag;
    logic [31:0] hit_cnt;
`ifdef RAY_SPHERE_DISC_OUT_EN
    logic signed [40:0] out_disc;
`endif

    ray_sphere_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ray_orig   (ray_orig),
        .ray_dir    (ray_dir),
        .sph_center (sph_center),
        .sph_rad    (sph_rad),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_hit    (out_hit),
        .out_tag    (out_tag),
        .hit_cnt    (hit_cnt)
`ifdef RAY_SPHERE_DISC_OUT_EN
        ,
        .out_disc   (out_disc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tag;
        bit         hit;
        longint     disc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          rdy_mode = 0;   // 0 always ready, 1 random, 2 manual
    logic        man_ready = 1'b1;
    bit          stall_prev = 0;
    logic [7:0]  tag_prev;
    logic        hit_prev;
    int unsigned exp_cnt = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model: spec arithmetic on plain integers
    function automatic longint comp(input logic [47:0] v, input int i);
        logic [47:0]        t;
        logic signed [15:0] s;
        t = v >> (16 * (2 - i));
        s = t[15:0];
        return longint'(s);
    endfunction

    function automatic longint sat20(input longint x);
        if (x > 524287) return 524287;
        if (x < -524288) return -524288;
        return x;
    endfunction

    task automatic model(input logic [47:0] o, input logic [47:0] d, input logic [47:0] c,
                         input logic [15:0] r, output bit hit, output longint disc);
        longint             oc[3];
        longint             dd[3];
        longint             a, h, cc, rr;
        logic signed [15:0] rs;
        for (int i = 0; i < 3; i++) begin
            oc[i] = comp(o, i) - comp(c, i);
            dd[i] = comp(d, i);
        end
        rs   = r;
        rr   = longint'(rs) * longint'(rs);
        a    = sat20((dd[0]*dd[0] + dd[1]*dd[1] + dd[2]*dd[2]) >>> 8);
        h    = sat20((oc[0]*dd[0] + oc[1]*dd[1] + oc[2]*dd[2]) >>> 8);
        cc   = sat20((oc[0]*oc[0] + oc[1]*oc[1] + oc[2]*oc[2] - rr) >>> 8);
        disc = h*h - a*cc;
        hit  = (disc > 0);
    endtask

    function automatic logic [47:0] v3(input int x, input int y, input int z);
        return {16'(x), 16'(y), 16'(z)};
    endfunction

    function automatic logic [15:0] rcomp(input int lim);
        int v;
        v = int'($urandom_range(0, 2 * lim)) - lim;
        return 16'(v);
    endfunction

    // ---------------- driver
    task automatic send(input logic [47:0] o, input logic [47:0] d, input logic [47:0] c,
                        input logic [15:0] r, input logic [7:0] tag,
                        input bit eh, input longint ed);
        int   waited = 0;
        bit   done = 0;
        logic acc;
        exp_t e;
        ray_orig   = o;
        ray_dir    = d;
        sph_center = c;
        sph_rad    = r;
        in_tag     = tag;
        in_valid   = 1'b1;
        while (!done) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                done = 1;
            end else begin
                waited++;
                if (waited > 1000) begin
                    n_err++;
                    $display("FAIL send_timeout: actual in_ready stuck low, required accept of tag %0d", tag);
                    $fatal(1);
                end
            end
        end
        e.tag  = tag;
        e.hit  = eh;
        e.disc = ed;
        sbq.push_back(e);
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [47:0] o, input logic [47:0] d, input logic [47:0] c,
                              input logic [15:0] r, input logic [7:0] tag);
        bit     h;
        longint dsc;
        model(o, d, c, r, h, dsc);
        send(o, d, c, r, tag, h, dsc);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", longint'(sbq.size()), 0);
    endtask

    // ---------------- output ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0)      out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
            else                    out_ready = man_ready;
        end
    end

    // ---------------- monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 0;
            exp_cnt    = 0;
            sbq.delete();
        end else begin
            check("in_ready", longint'(in_ready), longint'(!out_valid || out_ready));
            check("hit_cnt", longint'(hit_cnt), longint'(exp_cnt));
            if (!out_valid) check("hit_when_idle", longint'(out_hit), 0);
            if (stall_prev) begin
                check("stall_valid", longint'(out_valid), 1);
                check("stall_tag", longint'(out_tag), longint'(tag_prev));
                check("stall_hit", longint'(out_hit), longint'(hit_prev));
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: actual tag %0d, required no output", out_tag);
                end else begin
                    mon_e = sbq.pop_front();
                    check("out_tag", longint'(out_tag), longint'(mon_e.tag));
                    check("out_hit", longint'(out_hit), longint'(mon_e.hit));
`ifdef RAY_SPHERE_DISC_OUT_EN
                    check("out_disc", longint'(out_disc), mon_e.disc);
`endif
                    if (mon_e.hit) exp_cnt = exp_cnt + 1;
                end
            end
            stall_prev = out_valid && !out_ready;
            tag_prev   = out_tag;
            hit_prev   = out_hit;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1);
    end

    // ---------------- stimulus
    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_hit", longint'(out_hit), 0);
        check("rst_out_tag", longint'(out_tag), 0);
        check("rst_hit_cnt", longint'(hit_cnt), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;

        // 1: hit, disc = 0.25, valid 4 cycles after presentation
        send(v3(0, 0, 0), v3(0, 0, -256), v3(0, 0, -256), 16'd128, 8'd1, 1, 16384);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("latency", longint'(out_valid), longint'(i == 4));
        end
        drain();

        // 2: miss, disc = -0.75
        send(v3(0, 0, 0), v3(0, 256, 0), v3(0, 0, -256), 16'd128, 8'd2, 0, -49152);
        // 3: tangent and zero direction
        send(v3(0, 0, 0), v3(0, 256, 0), v3(0, 0, -256), 16'd256, 8'd3, 0, 0);
        send(v3(0, 0, 0), v3(0, 0, 0), v3(0, 0, -256), 16'd128, 8'd4, 0, 0);
        drain();

        // 4: five back-to-back with a 3-cycle stall mid-stream
        rdy_mode  = 2;
        man_ready = 1'b1;
        fork
            begin
                for (int t = 0; t < 5; t++) begin
                    send_model(v3(0, 0, 0), (t % 2 == 0) ? v3(0, 0, -256) : v3(0, 256, 0),
                               v3(0, 0, -256), 16'd128, 8'(t));
                end
            end
            begin
                repeat (4) @(posedge clk);
                man_ready = 1'b0;
                repeat (3) @(posedge clk);
                man_ready = 1'b1;
            end
        join
        drain();
        rdy_mode = 0;

        // 5: reset with three in flight
        for (int t = 0; t < 3; t++) begin
            send(v3(0, 0, 0), v3(0, 0, -256), v3(0, 0, -256), 16'd128, 8'(100 + t), 1, 16384);
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_hit_cnt", longint'(hit_cnt), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", longint'(in_ready), 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_stale", longint'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        send(v3(0, 0, 0), v3(0, 0, -256), v3(0, 0, -256), 16'd128, 8'd200, 1, 16384);
        drain();

        // 6: random rays with random back-pressure and bubbles
        rdy_mode = 1;
        for (int n = 0; n < 10000; n++) begin
            logic [47:0] o, d, c;
            logic [15:0] r;
            if ($urandom_range(0, 7) == 0) begin
                o = {16'($urandom()), 16'($urandom()), 16'($urandom())};
                d = {16'($urandom()), 16'($urandom()), 16'($urandom())};
                c = {16'($urandom()), 16'($urandom()), 16'($urandom())};
                r = 16'($urandom());
            end else begin
                o = {rcomp(1024), rcomp(1024), rcomp(1024)};
                d = {rcomp(512), rcomp(512), rcomp(512)};
                c = {rcomp(2048), rcomp(2048), rcomp(2048)};
                r = rcomp(1024);
            end
            send_model(o, d, c, r, 8'(n));
            if ($urandom_range(0, 9) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        rdy_mode = 0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
